// File: rtl/rom_port_arb_if.sv
// Fetch/data request ports plus the single-port memory strobe bundle around rom_port_arb.
// slave = the arbiter; master = the core ports and the rom together.
interface rom_port_arb_if #(
   parameter int ADDR_W = 12
);
   // fetch port
   logic              if_req_i;
   logic [ADDR_W+2:0] if_addr_i;
   logic              if_gnt_o;
   logic              if_rvalid_o;
   logic [31:0]       if_rdata_o;

   // data port
   logic              d_req_i;
   logic              d_we_i;
   logic [3:0]        d_be_i;
   logic [ADDR_W+2:0] d_addr_i;
   logic [31:0]       d_wdata_i;
   logic              d_gnt_o;
   logic              d_rvalid_o;
   logic [31:0]       d_rdata_o;

   // memory side
   logic              mem_ceb_o;
   logic              mem_web_o;
   logic [63:0]       mem_bweb_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [63:0]       mem_wdata_o;
   logic [63:0]       mem_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
      output d_gnt_o, d_rvalid_o, d_rdata_o,
      output mem_ceb_o, mem_web_o, mem_bweb_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
      input  d_gnt_o, d_rvalid_o, d_rdata_o,
      input  mem_ceb_o, mem_web_o, mem_bweb_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/rom_port_arb.sv
// Round-robin fetch/data arbiter for the 64-bit single-port rom; combinational grant, read data 1 cycle later.
// Requests hold until granted; responses cannot be stalled and are dropped if rst hits before delivery.
module rom_port_arb #(
   parameter int ADDR_W = 12
) (
   input  logic          clk,
   input  logic          rst,
   rom_port_arb_if.slave bus
);

   logic if_gnt;
   logic d_gnt;
   logic d_wr;
   logic d_lane;

   // 1 = data port was granted last, so fetch wins the next conflict
   logic last_q;

   logic rsp_vld_q;
   logic rsp_owner_q;   // 0 = fetch, 1 = data
   logic rsp_lane_q;

   logic [31:0] rsp_word;
   logic        addr_lsb_unused;

   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (!rst) begin
         if (bus.if_req_i && bus.d_req_i) begin
            if_gnt = last_q;
            d_gnt  = !last_q;
         end else begin
            if_gnt = bus.if_req_i;
            d_gnt  = bus.d_req_i;
         end
      end
   end

   assign d_wr   = d_gnt & bus.d_we_i;
   assign d_lane = bus.d_addr_i[2];

   always_comb begin
      bus.mem_bweb_o = '1;
      if (d_wr) begin
         for (int k = 0; k < 4; k++) begin
            if (bus.d_be_i[k]) begin
               if (d_lane)
                  bus.mem_bweb_o[32 + 8*k +: 8] = 8'h00;
               else
                  bus.mem_bweb_o[8*k +: 8] = 8'h00;
            end
         end
      end
   end

   assign bus.mem_ceb_o   = !(if_gnt | d_gnt);
   assign bus.mem_web_o   = !d_wr;
   assign bus.mem_addr_o  = if_gnt ? bus.if_addr_i[ADDR_W+2:3] : bus.d_addr_i[ADDR_W+2:3];
   assign bus.mem_wdata_o = {bus.d_wdata_i, bus.d_wdata_i};

   assign bus.if_gnt_o = if_gnt;
   assign bus.d_gnt_o  = d_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q      <= 1'b1;
         rsp_vld_q   <= 1'b0;
         rsp_owner_q <= 1'b0;
         rsp_lane_q  <= 1'b0;
      end else begin
         if (if_gnt)
            last_q <= 1'b0;
         else if (d_gnt)
            last_q <= 1'b1;
         rsp_vld_q   <= if_gnt | (d_gnt & !bus.d_we_i);
         rsp_owner_q <= d_gnt;
         rsp_lane_q  <= if_gnt ? bus.if_addr_i[2] : d_lane;
      end
   end

   // Gating with rst drops a response whose delivery cycle coincides with reset.
   assign rsp_word        = rsp_lane_q ? bus.mem_rdata_i[63:32] : bus.mem_rdata_i[31:0];
   assign bus.if_rvalid_o = rsp_vld_q & !rsp_owner_q & !rst;
   assign bus.d_rvalid_o  = rsp_vld_q & rsp_owner_q & !rst;
   assign bus.if_rdata_o  = rsp_word;
   assign bus.d_rdata_o   = rsp_word;

   assign addr_lsb_unused = ^{bus.if_addr_i[1:0], bus.d_addr_i[1:0]};

endmodule

// File: tb/tb_rom_port_arb.sv
// Directed bench for rom_port_arb with a behavioural single-port rom model.
module tb_rom_port_arb;
   localparam int AW = 12;
   localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   rom_port_arb_if #(.ADDR_W(AW)) bus ();
   rom_port_arb #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [63:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bus.mem_ceb_o === 1'b0) begin
         if (bus.mem_web_o === 1'b0)
            mem[bus.mem_addr_o] <= (mem[bus.mem_addr_o] & bus.mem_bweb_o) |
                                   (bus.mem_wdata_o & ~bus.mem_bweb_o);
         else
            bus.mem_rdata_i <= mem[bus.mem_addr_o];
      end
   end

   typedef struct {
      logic        if_req;
      logic [14:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [3:0]  d_be;
      logic [14:0] d_addr;
      logic [31:0] d_wdata;
      logic        e_ig;
      logic        e_dg;
      logic        e_ceb;
      logic        e_web;
      logic [63:0] e_bweb;
      logic [11:0] e_maddr;
      logic        e_irv;
      logic [31:0] e_ird;
      logic        e_drv;
      logic [31:0] e_drd;
   } vec_t;

   function automatic vec_t mk(logic ir, logic [14:0] ia, logic dr, logic we, logic [3:0] be,
                               logic [14:0] da, logic [31:0] wd, logic eig, logic edg,
                               logic eceb, logic eweb, logic [63:0] ebw, logic [11:0] ema,
                               logic eirv, logic [31:0] eird, logic edrv, logic [31:0] edrd);
      vec_t v;
      v.if_req = ir;  v.if_addr = ia; v.d_req = dr; v.d_we = we; v.d_be = be;
      v.d_addr = da;  v.d_wdata = wd; v.e_ig = eig; v.e_dg = edg; v.e_ceb = eceb;
      v.e_web = eweb; v.e_bweb = ebw; v.e_maddr = ema; v.e_irv = eirv; v.e_ird = eird;
      v.e_drv = edrv; v.e_drd = edrd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ir, input logic [14:0] ia, input logic dr, input logic we,
                        input logic [3:0] be, input logic [14:0] da, input logic [31:0] wd);
      bus.if_req_i  = ir;
      bus.if_addr_i = ia;
      bus.d_req_i   = dr;
      bus.d_we_i    = we;
      bus.d_be_i    = be;
      bus.d_addr_i  = da;
      bus.d_wdata_i = wd;
   endtask

   vec_t tbl [15];

   initial begin
      drive(1, 15'h28, 1, 1, 4'hF, 15'h18, 32'h0);

      // reset holds everything quiet even with requests present
      repeat (2) begin
         step();
         @(negedge clk);
         chk("rst_if_gnt", 64'(bus.if_gnt_o), 64'd0);
         chk("rst_d_gnt", 64'(bus.d_gnt_o), 64'd0);
         chk("rst_ceb", 64'(bus.mem_ceb_o), 64'd1);
         chk("rst_web", 64'(bus.mem_web_o), 64'd1);
         chk("rst_bweb", bus.mem_bweb_o, ALL1);
         chk("rst_rvalid", 64'({bus.if_rvalid_o, bus.d_rvalid_o}), 64'd0);
      end

      // preload words 5, 3 and 0 through the data port
      step();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      begin
         logic [14:0] pa [6];
         logic [31:0] pd [6];
         pa[0] = 15'h28; pd[0] = 32'h55667788;
         pa[1] = 15'h2C; pd[1] = 32'h11223344;
         pa[2] = 15'h18; pd[2] = 32'h89ABCDEF;
         pa[3] = 15'h1C; pd[3] = 32'h01234567;
         pa[4] = 15'h00; pd[4] = 32'h12345678;
         pa[5] = 15'h04; pd[5] = 32'hCAFEF00D;
         for (int i = 0; i < 6; i++) begin
            step();
            drive(0, 0, 1, 1, 4'hF, pa[i], pd[i]);
            @(negedge clk);
            chk("preload_gnt", 64'(bus.d_gnt_o), 64'd1);
         end
      end
      step();
      drive(0, 0, 0, 0, 0, 0, 0);

      tbl[0]  = mk(1, 15'h28, 0, 0, 4'h0, 15'h00, 32'h0,        1, 0, 0, 1, ALL1, 12'd5, 0, 32'h0, 0, 32'h0);
      tbl[1]  = mk(1, 15'h2C, 0, 0, 4'h0, 15'h00, 32'h0,        1, 0, 0, 1, ALL1, 12'd5, 1, 32'h55667788, 0, 32'h0);
      tbl[2]  = mk(0, 15'h00, 1, 1, 4'h2, 15'h2C, 32'hAABBCCDD, 0, 1, 0, 0, 64'hFFFF00FF_FFFFFFFF, 12'd5, 1, 32'h11223344, 0, 32'h0);
      tbl[3]  = mk(0, 15'h00, 1, 0, 4'h0, 15'h2C, 32'h0,        0, 1, 0, 1, ALL1, 12'd5, 0, 32'h0, 0, 32'h0);
      tbl[4]  = mk(0, 15'h00, 0, 0, 4'h0, 15'h00, 32'h0,        0, 0, 1, 1, ALL1, 12'd0, 0, 32'h0, 1, 32'h1122CC44);
      tbl[5]  = mk(0, 15'h00, 1, 1, 4'hF, 15'h18, 32'hDEADBEEF, 0, 1, 0, 0, 64'hFFFFFFFF_00000000, 12'd3, 0, 32'h0, 0, 32'h0);
      tbl[6]  = mk(1, 15'h18, 0, 0, 4'h0, 15'h00, 32'h0,        1, 0, 0, 1, ALL1, 12'd3, 0, 32'h0, 0, 32'h0);
      tbl[7]  = mk(0, 15'h00, 0, 0, 4'h0, 15'h00, 32'h0,        0, 0, 1, 1, ALL1, 12'd0, 1, 32'hDEADBEEF, 0, 32'h0);
      tbl[8]  = mk(0, 15'h00, 1, 1, 4'h0, 15'h1C, 32'h0,        0, 1, 0, 0, ALL1, 12'd3, 0, 32'h0, 0, 32'h0);
      tbl[9]  = mk(1, 15'h1C, 0, 0, 4'h0, 15'h00, 32'h0,        1, 0, 0, 1, ALL1, 12'd3, 0, 32'h0, 0, 32'h0);
      tbl[10] = mk(0, 15'h00, 0, 0, 4'h0, 15'h00, 32'h0,        0, 0, 1, 1, ALL1, 12'd0, 1, 32'h01234567, 0, 32'h0);
      tbl[11] = mk(1, 15'h00, 1, 0, 4'h0, 15'h28, 32'h0,        0, 1, 0, 1, ALL1, 12'd5, 0, 32'h0, 0, 32'h0);
      tbl[12] = mk(1, 15'h00, 1, 0, 4'h0, 15'h2C, 32'h0,        1, 0, 0, 1, ALL1, 12'd0, 0, 32'h0, 1, 32'h55667788);
      tbl[13] = mk(0, 15'h00, 1, 0, 4'h0, 15'h2C, 32'h0,        0, 1, 0, 1, ALL1, 12'd5, 1, 32'h12345678, 0, 32'h0);
      tbl[14] = mk(0, 15'h00, 0, 0, 4'h0, 15'h00, 32'h0,        0, 0, 1, 1, ALL1, 12'd0, 0, 32'h0, 1, 32'h1122CC44);

      for (int i = 0; i < 15; i++) begin
         step();
         drive(tbl[i].if_req, tbl[i].if_addr, tbl[i].d_req, tbl[i].d_we, tbl[i].d_be,
               tbl[i].d_addr, tbl[i].d_wdata);
         @(negedge clk);
         chk($sformatf("v%0d_if_gnt", i), 64'(bus.if_gnt_o), 64'(tbl[i].e_ig));
         chk($sformatf("v%0d_d_gnt", i), 64'(bus.d_gnt_o), 64'(tbl[i].e_dg));
         chk($sformatf("v%0d_ceb", i), 64'(bus.mem_ceb_o), 64'(tbl[i].e_ceb));
         chk($sformatf("v%0d_web", i), 64'(bus.mem_web_o), 64'(tbl[i].e_web));
         chk($sformatf("v%0d_if_rvalid", i), 64'(bus.if_rvalid_o), 64'(tbl[i].e_irv));
         chk($sformatf("v%0d_d_rvalid", i), 64'(bus.d_rvalid_o), 64'(tbl[i].e_drv));
         if (!tbl[i].e_ceb) begin
            chk($sformatf("v%0d_bweb", i), bus.mem_bweb_o, tbl[i].e_bweb);
            chk($sformatf("v%0d_maddr", i), 64'(bus.mem_addr_o), 64'(tbl[i].e_maddr));
         end
         if (!tbl[i].e_web)
            chk($sformatf("v%0d_wdata", i), bus.mem_wdata_o, {tbl[i].d_wdata, tbl[i].d_wdata});
         if (tbl[i].e_irv)
            chk($sformatf("v%0d_if_rdata", i), 64'(bus.if_rdata_o), 64'(tbl[i].e_ird));
         if (tbl[i].e_drv)
            chk($sformatf("v%0d_d_rdata", i), 64'(bus.d_rdata_o), 64'(tbl[i].e_drd));
      end

      // conflict right after reset: F,D,F,D,F,D with responses routed to the owner
      step();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      rst = 1'b0;
      drive(1, 15'h28, 1, 0, 4'h0, 15'h18, 32'h0);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) step();
         if (i == 6) drive(0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         if (i < 6) begin
            chk($sformatf("cf%0d_if_gnt", i), 64'(bus.if_gnt_o), 64'(i % 2 == 0));
            chk($sformatf("cf%0d_d_gnt", i), 64'(bus.d_gnt_o), 64'(i % 2 == 1));
         end
         if (i > 0) begin
            chk($sformatf("cf%0d_if_rvalid", i), 64'(bus.if_rvalid_o), 64'((i - 1) % 2 == 0));
            chk($sformatf("cf%0d_d_rvalid", i), 64'(bus.d_rvalid_o), 64'((i - 1) % 2 == 1));
            if ((i - 1) % 2 == 0)
               chk($sformatf("cf%0d_if_rdata", i), 64'(bus.if_rdata_o), 64'h55667788);
            else
               chk($sformatf("cf%0d_d_rdata", i), 64'(bus.d_rdata_o), 64'hDEADBEEF);
         end
      end

      // reset the cycle after a fetch grant drops the response
      step();
      drive(1, 15'h28, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rm_if_gnt", 64'(bus.if_gnt_o), 64'd1);
      step();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rm_if_rvalid0", 64'(bus.if_rvalid_o), 64'd0);
      chk("rm_ceb0", 64'(bus.mem_ceb_o), 64'd1);
      step();
      @(negedge clk);
      chk("rm_if_rvalid1", 64'(bus.if_rvalid_o), 64'd0);
      chk("rm_ceb1", 64'(bus.mem_ceb_o), 64'd1);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rm_if_rvalid2", 64'(bus.if_rvalid_o), 64'd0);

      // idle
      for (int i = 0; i < 10; i++) begin
         step();
         @(negedge clk);
         chk("idle_ceb", 64'(bus.mem_ceb_o), 64'd1);
         chk("idle_gnt", 64'({bus.if_gnt_o, bus.d_gnt_o}), 64'd0);
         chk("idle_rvalid", 64'({bus.if_rvalid_o, bus.d_rvalid_o}), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rom_port_arb.md
# rom_port_arb

Two-requester access controller for the single-port 64-bit `rom` memory. It arbitrates round-robin between the instruction-fetch port (read-only) and the data port (read/write), one access per cycle. It maps 32-bit byte-addressed requests onto 64-bit memory words and active-low bit-write enables, and returns read data one cycle after grant. It sits between the core's fetch/LSU interfaces and the `rom` instance.

## Interface

- `ADDR_W`, default 12: memory word-index width (word count = 2^ADDR_W). Port byte addresses are `ADDR_W+3` bits wide.
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `if_req_i` in 1: fetch request valid.
- `if_addr_i` in ADDR_W+3: fetch byte address.
- `if_gnt_o` out 1: fetch request accepted this cycle.
- `if_rvalid_o` out 1: fetch read data valid.
- `if_rdata_o` out 32: fetch read data.
- `d_req_i` in 1: data request valid.
- `d_we_i` in 1: 1 = write, 0 = read.
- `d_be_i` in 4: byte enables for writes.
- `d_addr_i` in ADDR_W+3: data byte address.
- `d_wdata_i` in 32: write data.
- `d_gnt_o` out 1: data request accepted this cycle.
- `d_rvalid_o` out 1: data read data valid; reads only.
- `d_rdata_o` out 32: data read data.
- `mem_ceb_o` out 1: memory chip enable, active-low.
- `mem_web_o` out 1: memory write enable, active-low.
- `mem_bweb_o` out 64: bit-write enable, active-low per bit.
- `mem_addr_o` out ADDR_W: memory word index.
- `mem_wdata_o` out 64: memory write data.
- `mem_rdata_i` in 64: memory read data, valid one cycle after `ceb` = 0.

## Operation

**Handshake**
- A request is held by the requester until its `gnt` is asserted.
- Grant is combinational in the same cycle as the request.
- At most one grant per cycle.

**Arbitration**
- State is a 1-bit round-robin pointer `last`, where 0 = fetch was granted last.
- If only one port requests, that port is granted.
- If both ports request, the port that was not granted last wins.
- `last` updates on every grant.
- Reset value of `last` is 1, so fetch wins the first conflict.

**Address mapping**
- Word index = `addr[ADDR_W+2:3]`.
- Lane = `addr[2]`: 0 selects bits [31:0], 1 selects bits [63:32].
- `addr[1:0]` is ignored.

**Memory drive (combinational from the grant)**
- `mem_ceb_o` = 0 when any grant, else 1.
- `mem_web_o` = 0 only for a granted data write, else 1.
- `mem_wdata_o` = {wdata, wdata}.
- `mem_bweb_o`: all 1 except that for each `d_be_i[k]` = 1, the 8 bits of byte k in the selected lane are 0.
- A write with `be` = 0 still performs a memory cycle but modifies nothing.
- When idle, `mem_addr_o` and `mem_wdata_o` values are don't-care.

**Response pipeline (registered)**
- On a granted read, register the owner (fetch or data) and the lane.
- Next cycle, assert that owner's `rvalid` and drive its `rdata` from the registered lane of `mem_rdata_i`.
- Writes produce no response.
- Responses cannot be back-pressured; requesters must accept them.
- A new grant may occur in the same cycle a response is returned (fully pipelined).

## Timing

- Grant in cycle N, with memory strobed at the end of cycle N.
- Read data is returned in cycle N+1 (latency 1).
- A write is committed at the end of cycle N.
- Throughput is 1 access per cycle.
- With both ports requesting continuously, grants alternate; each port waits at most 1 cycle.
- Read-after-write to the same word on consecutive cycles returns the new data, because the single port is sequential.
- Reset values: `if_rvalid_o` = `d_rvalid_o` = 0 and the pipeline owner is cleared.
- Grants depend only on current requests, so grants and `mem_ceb_o` = 0 can occur in the cycle following reset deassertion.
- While `rst` = 1:
  - `if_gnt_o` = `d_gnt_o` = 0.
  - `mem_ceb_o` = 1, `mem_web_o` = 1, `mem_bweb_o` = all 1.
- Reset asserted in the cycle after a read grant drops that response: `rvalid` stays 0.
- `rdata` outputs are don't-care when the matching `rvalid` = 0.

## Test plan

- **Fetch only:** preload word 5 = 64'h1122334455667788, fetch reads addr 0x28 and 0x2C → `if_rvalid_o` one cycle after each grant with 0x55667788 and 0x11223344.
- **Data byte write:** write `be`=4'b0010, addr 0x2C, wdata 0xAABBCCDD → `mem_bweb_o` = all 1 except bits [47:40] = 0; word 5 becomes 64'h1122CC4455667788; `d_rvalid_o` stays 0.
- **Conflict:** both ports request continuously for 6 cycles after reset → grant order F,D,F,D,F,D; each `rvalid` goes to the correct owner one cycle after its grant.
- **Back-to-back:** data write word 3 then fetch read word 3 on the next cycle → fetch returns the written value.
- **Reset mid-operation:** assert `rst` the cycle after a fetch grant → `if_rvalid_o` = 0 in that cycle and the next; `mem_ceb_o` = 1 throughout reset.
- **Idle:** no requests for 10 cycles → `mem_ceb_o` = 1 and no grants or `rvalid`s.
